// File: rtl/hls_phi_add_unit.sv
// hls_phi_add_unit: loop-carried-value unit for generated HLS datapaths.
// A branch register remembers the most recently exited basic block, a phi
// selector picks the incoming value whose predecessor ID matches it (lowest
// pair wins on ties), and an adder adds an operand to the selected value.
// The sum can be captured into a result register. There is no sequencing
// here; the enclosing controller strobes br_en and res_ld.
module hls_phi_add_unit #(
   parameter int NB_PAIR  = 2,
   parameter int WIDTH    = 8,
   parameter int BB_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NB_PAIR*WIDTH-1:0]    phi_in,
   input  logic [NB_PAIR*BB_WIDTH-1:0] phi_s,
   input  logic                        br_en,
   input  logic [BB_WIDTH-1:0]         br_from,
   input  logic [WIDTH-1:0]            add_in1,
   input  logic                        res_ld,
   output logic [BB_WIDTH-1:0]         last_block,
   output logic [WIDTH-1:0]            phi_out,
   output logic                        phi_hit,
   output logic [WIDTH-1:0]            add_out,
   output logic                        add_cout,
   output logic [WIDTH-1:0]            res_q
);

   logic [BB_WIDTH-1:0] last_block_q;
   logic [BB_WIDTH-1:0] last_block_d;
   logic [WIDTH-1:0]    result_q;
   logic [WIDTH-1:0]    result_d;

   logic [NB_PAIR-1:0]  pair_match;
   logic [WIDTH-1:0]    pair_val [NB_PAIR];
   logic [WIDTH-1:0]    sel_val;
   logic                sel_hit;
   logic [WIDTH:0]      sum_full;

   // Unpack the pairs and compare each predecessor ID against the
   // registered branch ID in parallel.
   generate
      for (genvar gi = 0; gi < NB_PAIR; gi++) begin : g_pair
         assign pair_val[gi]   = phi_in[gi*WIDTH +: WIDTH];
         assign pair_match[gi] = (phi_s[gi*BB_WIDTH +: BB_WIDTH] == last_block_q);
      end
   endgenerate

   // Priority select: the first matching pair (lowest index) wins; no match
   // yields zero so the adder sees a defined operand.
   always_comb begin
      sel_val = '0;
      sel_hit = 1'b0;
      for (int i = 0; i < NB_PAIR; i++) begin
         if (pair_match[i] && !sel_hit) begin
            sel_val = pair_val[i];
            sel_hit = 1'b1;
         end
      end
   end

   // Unsigned add one bit wider than the data so the carry is kept.
   always_comb begin
      sum_full = {1'b0, sel_val} + {1'b0, add_in1};
   end

   // Next-state for both registers; each holds unless its strobe is high.
   // The result register samples the sum built from the current (old)
   // last_block, so a simultaneous branch only affects the next cycle.
   always_comb begin
      last_block_d = last_block_q;
      result_d     = result_q;
      if (br_en) begin
         last_block_d = br_from;
      end
      if (res_ld) begin
         result_d = sum_full[WIDTH-1:0];
      end
   end

   // State registers with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_block_q <= '0;
         result_q     <= '0;
      end else begin
         last_block_q <= last_block_d;
         result_q     <= result_d;
      end
   end

   assign last_block = last_block_q;
   assign phi_out    = sel_val;
   assign phi_hit    = sel_hit;
   assign add_out    = sum_full[WIDTH-1:0];
   assign add_cout   = sum_full[WIDTH];
   assign res_q      = result_q;

endmodule

// File: tb/tb_hls_phi_add_unit.sv
// Bench for hls_phi_add_unit: a table of combinational select/add vectors,
// each followed by a result-register load checked through a scoreboard
// queue, plus hand-written reset, counting-loop, hold and same-cycle
// branch/load sequences.
module tb_hls_phi_add_unit;

   localparam int NB = 2;
   localparam int W  = 8;
   localparam int BW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [NB*W-1:0] phi_in;
   logic [NB*BW-1:0] phi_s;
   logic            br_en;
   logic [BW-1:0]   br_from;
   logic [W-1:0]    add_in1;
   logic            res_ld;
   logic [BW-1:0]   last_block;
   logic [W-1:0]    phi_out;
   logic            phi_hit;
   logic [W-1:0]    add_out;
   logic            add_cout;
   logic [W-1:0]    res_q;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q [$];

   hls_phi_add_unit #(.NB_PAIR(NB), .WIDTH(W), .BB_WIDTH(BW)) dut (
      .clk(clk), .rst(rst), .phi_in(phi_in), .phi_s(phi_s),
      .br_en(br_en), .br_from(br_from), .add_in1(add_in1), .res_ld(res_ld),
      .last_block(last_block), .phi_out(phi_out), .phi_hit(phi_hit),
      .add_out(add_out), .add_cout(add_cout), .res_q(res_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lb;
      logic [31:0] s1, s0;
      logic [7:0]  v1, v0;
      logic [7:0]  a;
      logic [7:0]  e_out;
      logic        e_hit;
      logic [7:0]  e_sum;
      logic        e_c;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Commit a branch to block id and confirm it registered.
   task automatic set_lb(input logic [31:0] id);
      br_en = 1'b1; br_from = id; res_ld = 1'b0;
      step();
      br_en = 1'b0;
      check("last_block", last_block, id);
   endtask

   // Pulse res_ld with the bench's expected sum queued, then compare.
   task automatic load(input logic [7:0] exp_sum);
      logic [7:0] e;
      res_ld = 1'b1;
      exp_q.push_back(exp_sum);
      step();
      res_ld = 1'b0;
      e = exp_q.pop_front();
      check("res_q", 32'(res_q), 32'(e));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] model;
      vecs[0] = '{32'd0, 32'd1, 32'd0, 8'd7, 8'd0, 8'd1, 8'd0, 1'b1, 8'd1, 1'b0};
      vecs[1] = '{32'd1, 32'd1, 32'd0, 8'd7, 8'd0, 8'd1, 8'd7, 1'b1, 8'd8, 1'b0};
      vecs[2] = '{32'd5, 32'd1, 32'd0, 8'd7, 8'd0, 8'h33, 8'd0, 1'b0, 8'h33, 1'b0};
      vecs[3] = '{32'd3, 32'd3, 32'd3, 8'd9, 8'd4, 8'd2, 8'd4, 1'b1, 8'd6, 1'b0};
      vecs[4] = '{32'd0, 32'd1, 32'd0, 8'd7, 8'hFF, 8'd1, 8'hFF, 1'b1, 8'd0, 1'b1};
      vecs[5] = '{32'd1, 32'd1, 32'd0, 8'h80, 8'd0, 8'h80, 8'h80, 1'b1, 8'd0, 1'b1};
      vecs[6] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 8'hAA, 8'h11, 8'h10, 8'hAA, 1'b1, 8'hBA, 1'b0};

      // Reset with both strobes active and a nonzero sum available.
      rst = 1'b0; br_en = 1'b1; res_ld = 1'b1; br_from = 32'h55;
      phi_s = {32'd1, 32'd0}; phi_in = {8'd7, 8'd3}; add_in1 = 8'd5;
      step();
      step();
      check("rst last_block", last_block, 32'd0);
      check("rst res_q", 32'(res_q), 32'd0);
      rst = 1'b1; br_en = 1'b0; res_ld = 1'b0;
      step();
      check("post-rst last_block", last_block, 32'd0);
      check("post-rst res_q", 32'(res_q), 32'd0);

      // Table-driven select/add vectors, each followed by a load.
      for (int i = 0; i < 7; i++) begin
         set_lb(vecs[i].lb);
         phi_s = {vecs[i].s1, vecs[i].s0};
         phi_in = {vecs[i].v1, vecs[i].v0};
         add_in1 = vecs[i].a;
         #1;
         check($sformatf("v%0d phi_out", i), 32'(phi_out), 32'(vecs[i].e_out));
         check($sformatf("v%0d phi_hit", i), 32'(phi_hit), 32'(vecs[i].e_hit));
         check($sformatf("v%0d add_out", i), 32'(add_out), 32'(vecs[i].e_sum));
         check($sformatf("v%0d add_cout", i), 32'(add_cout), 32'(vecs[i].e_c));
         load(vecs[i].e_sum);
      end

      // Counting loop: i = phi(0, i+1); pair 1 carries res_q back.
      rst = 1'b0; step(); rst = 1'b1;
      phi_s = {32'd1, 32'd0}; add_in1 = 8'd1;
      phi_in = {res_q, 8'd0};
      #1;
      check("loop init phi_out", 32'(phi_out), 32'd0);
      load(8'd1);
      model = 8'd1;
      for (int k = 0; k < 3; k++) begin
         phi_in = {res_q, 8'd0};
         set_lb(32'd1);
         #1;
         check($sformatf("loop%0d phi_out", k), 32'(phi_out), 32'(model));
         load(model + 8'd1);
         model = model + 8'd1;
      end

      // Hold: no strobes, br_from changing, registers keep their values.
      br_from = 32'd7; br_en = 1'b0; res_ld = 1'b0;
      step();
      check("hold last_block", last_block, 32'd1);
      check("hold res_q", 32'(res_q), 32'd4);

      // Same-cycle branch and load: result uses the old selection.
      set_lb(32'd0);
      phi_s = {32'd1, 32'd0}; phi_in = {8'h10, 8'h20}; add_in1 = 8'd1;
      br_en = 1'b1; br_from = 32'd1;
      load(8'h21);
      br_en = 1'b0;
      check("simul last_block", last_block, 32'd1);
      check("simul phi_out new", 32'(phi_out), 32'h10);
      check("simul add_out new", 32'(add_out), 32'h11);

      // Mid-operation reset discards a pending branch and load.
      rst = 1'b0; br_en = 1'b1; br_from = 32'd9; res_ld = 1'b1;
      step();
      rst = 1'b1; br_en = 1'b0; res_ld = 1'b0;
      check("midrst last_block", last_block, 32'd0);
      check("midrst res_q", 32'(res_q), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
